mips_multiciclo: RTL

//  Multi-cycle MIPS-subset core: successor to the single-cycle top level. Shares one ALU and
//  one unified instruction/data memory port across cycles, driven by a control FSM.
//  The memory port uses a req/ready handshake, so slow or wait-stated memories connect directly.

---
 rtl/mips_multiciclo.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multiciclo.sv
// Multi-cycle MIPS-subset core sharing one ALU and one req/ready memory port across FETCH..WB.
// Define MIPS_MC_HILO_MULT_EN to add HI/LO registers with mult/mfhi/mflo.
module mips_multiciclo #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       PC_out,
    output logic [31:0]       ULA_out,
    output logic [2:0]        state_out,
    output logic              retired,
    output logic              halted
);
    typedef enum logic [2:0] {
        FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd7
    } state_t;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_ADD = 6'h20, F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;
    localparam logic [5:0] F_MFHI = 6'h10, F_MFLO = 6'h12, F_MULT = 6'h18;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [31:0] tgt_q, tgt_d, ula_q, ula_d, mdr_q, mdr_d;
    logic [31:0] regs_q [32];

    logic        rf_we, req_c, we_c, retire_c;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, addr_c, eff_addr, hilo_val;

    logic [5:0]  opc, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm_sx;
    logic        is_r, is_alu_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, legal;
    logic        is_mult, is_mfhi, is_mflo;

    function automatic logic [31:0] alu(input logic [5:0] f, input logic [31:0] x,
                                        input logic [31:0] y, input logic [4:0] sh);
        case (f)
            F_ADD:   alu = x + y;
            F_SUB:   alu = x - y;
            F_AND:   alu = x & y;
            F_OR:    alu = x | y;
            F_SLT:   alu = {31'd0, $signed(x) < $signed(y)};
            F_SLL:   alu = y << sh;
            F_SRL:   alu = y >> sh;
            default: alu = '0;
        endcase
    endfunction

    assign opc      = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign shamt    = ir_q[10:6];
    assign funct    = ir_q[5:0];
    assign imm_sx   = {{16{ir_q[15]}}, ir_q[15:0]};
    assign eff_addr = a_q + imm_sx;

    assign is_r     = (opc == OP_R);
    assign is_alu_r = is_r && (funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL});
    assign is_addi  = (opc == OP_ADDI);
    assign is_lw    = (opc == OP_LW);
    assign is_sw    = (opc == OP_SW);
    assign is_beq   = (opc == OP_BEQ);
    assign is_bne   = (opc == OP_BNE);
    assign is_j     = (opc == OP_J);
    assign is_jal   = (opc == OP_JAL);
    assign legal    = is_alu_r | is_addi | is_lw | is_sw | is_beq | is_bne | is_j | is_jal
                    | is_mult | is_mfhi | is_mflo;

`ifdef MIPS_MC_HILO_MULT_EN
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic signed [63:0] prod;

    assign is_mult  = is_r && (funct == F_MULT);
    assign is_mfhi  = is_r && (funct == F_MFHI);
    assign is_mflo  = is_r && (funct == F_MFLO);
    assign prod     = $signed(a_q) * $signed(b_q);
    assign {hi_d, lo_d} = (state_q == EXEC && is_mult) ? prod : {hi_q, lo_q};
    assign hilo_val = is_mfhi ? hi_q : lo_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end
`else
    assign is_mult  = 1'b0;
    assign is_mfhi  = 1'b0;
    assign is_mflo  = 1'b0;
    assign hilo_val = '0;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        tgt_d    = tgt_q;
        ula_d    = ula_q;
        mdr_d    = mdr_q;
        req_c    = 1'b0;
        we_c     = 1'b0;
        addr_c   = pc_q;
        retire_c = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = rd;
        rf_wdata = ula_q;
        unique case (state_q)
            FETCH: begin
                req_c = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d     = regs_q[rs];
                b_d     = regs_q[rt];
                tgt_d   = pc_q + {imm_sx[29:0], 2'b00};
                state_d = legal ? EXEC : HALT;
            end
            EXEC: begin
                state_d = FETCH;
                if (is_alu_r) begin
                    ula_d   = alu(funct, a_q, b_q, shamt);
                    state_d = WB;
                end else if (is_mfhi || is_mflo) begin
                    ula_d   = hilo_val;
                    state_d = WB;
                end else if (is_mult) begin
                    retire_c = 1'b1;
                end else if (is_addi) begin
                    ula_d   = eff_addr;
                    state_d = WB;
                end else if (is_lw || is_sw) begin
                    // A misaligned address halts before any memory access is issued
                    ula_d   = eff_addr;
                    state_d = (eff_addr[1:0] != 2'b00) ? HALT : MEM;
                end else if (is_beq || is_bne) begin
                    if ((a_q == b_q) == is_beq) pc_d = tgt_q;
                    retire_c = 1'b1;
                end else begin
                    pc_d     = {pc_q[31:28], ir_q[25:0], 2'b00};
                    retire_c = 1'b1;
                    if (is_jal) begin
                        rf_we    = 1'b1;
                        rf_waddr = 5'd31;
                        rf_wdata = pc_q;
                    end
                end
            end
            MEM: begin
                req_c  = 1'b1;
                we_c   = is_sw;
                addr_c = ula_q;
                if (mem_ready) begin
                    if (is_lw) begin
                        mdr_d   = mem_rdata;
                        state_d = WB;
                    end else begin
                        retire_c = 1'b1;
                        state_d  = FETCH;
                    end
                end
            end
            WB: begin
                rf_we    = 1'b1;
                retire_c = 1'b1;
                state_d  = FETCH;
                if (!is_r) rf_waddr = rt;
                if (is_lw) rf_wdata = mdr_q;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            ula_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ula_q   <= ula_d;
        end
    end

    always_ff @(posedge clock) begin
        a_q   <= a_d;
        b_q   <= b_d;
        tgt_q <= tgt_d;
        mdr_q <= mdr_d;
    end

    // $0 is never written, so it always reads back as zero
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (rf_we && rf_waddr != 5'd0) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    assign mem_req   = req_c & ~reset;
    assign mem_we    = we_c;
    assign mem_addr  = addr_c[ADDR_W-1:0];
    assign mem_wdata = b_q;
    assign PC_out    = pc_q;
    assign ULA_out   = ula_q;
    assign state_out = state_q;
    assign retired   = retire_c & ~reset;
    assign halted    = (state_q == HALT) & ~reset;
endmodule
